wallace_product_accumulator: RTL and testbench

- Sequential stage directly downstream of the final reduction layer of the approximate 8-bit Wallace tree multiplier.
- Registers each 16-bit product, formed from the tree's final layer sum/carry bits, and accumulates a frame of frame_len products into a wide sum.
- Presents each finished frame sum over a valid/ready handshake.
- Turns the combinational multiplier into a multiply-accumulate datapath.

---
 rtl/wallace_acc_pkg.sv | 20 ++
 rtl/wallace_product_accumulator_if.sv | 26 ++
 rtl/one_bit_full_adder.sv | 11 +
 rtl/one_bit_half_adder.sv | 10 +
 rtl/wallace_acc_adder.sv | 26 ++
 rtl/wallace_product_accumulator.sv | 122 ++++++++++++
 tb/tb_wallace_product_accumulator.sv | 302 ++++++++++++++++++++++++++++++
 7 files changed

// File: rtl/wallace_acc_pkg.sv
// Shared types and defaults for the Wallace-tree product accumulator.
package wallace_acc_pkg;

  localparam int unsigned PROD_W_DEF = 16;
  localparam int unsigned ACC_W_DEF  = 24;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } acc_state_e;

  // All-ones value of width w (w < 64), used as the saturation clamp.
  function automatic logic [63:0] sat_ones(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/wallace_product_accumulator_if.sv
// Product-beat input channel and frame-result output channel.
interface wallace_product_accumulator_if #(
  parameter int unsigned PROD_W = wallace_acc_pkg::PROD_W_DEF,
  parameter int unsigned ACC_W  = wallace_acc_pkg::ACC_W_DEF,
  parameter int unsigned CNT_W  = wallace_acc_pkg::CNT_W_DEF
);
  logic [CNT_W-1:0]  frame_len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output frame_len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_overflow
  );

  modport slave (
    input  frame_len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_overflow
  );
endinterface

// File: rtl/one_bit_full_adder.sv
// Single-bit full adder, ripple cell of the accumulator adder.
module one_bit_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/one_bit_half_adder.sv
// Single-bit half adder, LSB cell of the accumulator adder.
module one_bit_half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// File: rtl/wallace_acc_adder.sv
// W-bit ripple carry-propagate adder: half adder at bit 0, full adders above.
module wallace_acc_adder
  import wallace_acc_pkg::*;
#(
  parameter int unsigned W = ACC_W_DEF
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  logic [W-1:0] carry;

  one_bit_half_adder u_ha0 (
    .a_i(a_i[0]), .b_i(b_i[0]), .s_o(sum_o[0]), .c_o(carry[0])
  );

  for (genvar i = 1; i < W; i++) begin : g_fa
    one_bit_full_adder u_fa (
      .a_i(a_i[i]), .b_i(b_i[i]), .c_i(carry[i-1]),
      .s_o(sum_o[i]), .c_o(carry[i])
    );
  end

  assign cout_o = carry[W-1];
endmodule

// File: rtl/wallace_product_accumulator.sv
// Registers Wallace-tree products and accumulates frames of frame_len beats,
// presenting each frame sum over a valid/ready handshake.
module wallace_product_accumulator
  import wallace_acc_pkg::*;
#(
  parameter int unsigned PROD_W   = PROD_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter bit          SATURATE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  wallace_product_accumulator_if.slave bus,
  output logic busy
);
  localparam logic [ACC_W-1:0] ACC_ONES = ACC_W'(sat_ones(ACC_W));

  acc_state_e        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [PROD_W-1:0] p_q, p_d;
  logic              pvld_q, pvld_d;
  logic              ovf_q, ovf_d;

  logic              beat;
  logic [CNT_W-1:0]  len_eff;
  logic [ACC_W-1:0]  add_sum;
  logic              add_cout;

  wallace_acc_adder #(.W(ACC_W)) u_adder (
    .a_i   (acc_q),
    .b_i   (ACC_W'(p_q)),
    .sum_o (add_sum),
    .cout_o(add_cout)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    p_d     = p_q;
    pvld_d  = 1'b0;
    ovf_d   = ovf_q;

    bus.in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    bus.out_valid = (state_q == DONE);
    busy          = (state_q != IDLE);
    beat          = bus.in_valid && bus.in_ready;
    len_eff       = (bus.frame_len == '0) ? CNT_W'(1) : bus.frame_len;

    if (pvld_q) begin
      acc_d = (SATURATE && add_cout) ? ACC_ONES : add_sum;
      if (add_cout) ovf_d = 1'b1;
    end

    if (beat) begin
      p_d    = bus.in_product;
      pvld_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (beat) begin
          len_d   = len_eff;
          cnt_d   = CNT_W'(1);
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len_eff == CNT_W'(1)) ? FLUSH : ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_q + CNT_W'(1)) == len_q) state_d = FLUSH;
        end
      end
      // Stay until the final product has been added, so out_valid sees a registered sum.
      FLUSH: begin
        if (!pvld_q) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      pvld_d  = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      p_q     <= '0;
      pvld_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      p_q     <= p_d;
      pvld_q  <= pvld_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_sum      = acc_q;
  assign bus.out_count    = len_q;
  assign bus.out_overflow = ovf_q;
endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Scoreboard bench: three accumulator configurations driven in lock step.
module tb_wallace_product_accumulator;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [7:0]  frame_len;
  logic        in_valid;
  logic [15:0] in_product;
  logic        out_ready;
  logic        rdy_force;
  logic        rand_rdy;
  logic        rnd_rdy;
  logic        busy_a, busy_w, busy_s;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    longint unsigned total;
    int              len;
    int              vcyc;
  } exp_t;
  exp_t exp_q[$];

  longint unsigned m_total;
  int              m_beats;
  int              m_len;
  bit              m_in_frame;
  bit              prev_valid;

  wallace_product_accumulator_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) ifa ();
  wallace_product_accumulator_if #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) ifw ();
  wallace_product_accumulator_if #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) ifs ();

  assign ifa.frame_len = frame_len;  assign ifw.frame_len = frame_len;  assign ifs.frame_len = frame_len;
  assign ifa.in_valid = in_valid;    assign ifw.in_valid = in_valid;    assign ifs.in_valid = in_valid;
  assign ifa.in_product = in_product; assign ifw.in_product = in_product; assign ifs.in_product = in_product;
  assign ifa.out_ready = out_ready;  assign ifw.out_ready = out_ready;  assign ifs.out_ready = out_ready;
  assign out_ready = rand_rdy ? rnd_rdy : rdy_force;

  wallace_product_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8), .SATURATE(1'b0)) u_a (
    .clk(clk), .rst(rst), .clear(clear), .bus(ifa.slave), .busy(busy_a));
  wallace_product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8), .SATURATE(1'b0)) u_w (
    .clk(clk), .rst(rst), .clear(clear), .bus(ifw.slave), .busy(busy_w));
  wallace_product_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8), .SATURATE(1'b1)) u_s (
    .clk(clk), .rst(rst), .clear(clear), .bus(ifs.slave), .busy(busy_s));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    rnd_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the frame result is the exact sum, reduced by the width rule.
  function automatic longint unsigned ref_sum(input longint unsigned t, input int w, input bit sat);
    longint unsigned m;
    m = 64'd1 << w;
    if (t >= m) return sat ? (m - 1) : (t % m);
    return t;
  endfunction

  function automatic longint unsigned ref_ovf(input longint unsigned t, input int w);
    return (t >= (64'd1 << w)) ? 64'd1 : 64'd0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("lockstep_in_ready_w", ifw.in_ready, ifa.in_ready);
      chk("lockstep_valid_s", ifs.out_valid, ifa.out_valid);
      if (ifa.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", ifa.out_valid, 0);
        end else begin
          chk("sum_acc24", ifa.out_sum, ref_sum(exp_q[0].total, 24, 1'b0));
          chk("sum_acc17_wrap", ifw.out_sum, ref_sum(exp_q[0].total, 17, 1'b0));
          chk("sum_acc17_sat", ifs.out_sum, ref_sum(exp_q[0].total, 17, 1'b1));
          chk("ovf_acc24", ifa.out_overflow, ref_ovf(exp_q[0].total, 24));
          chk("ovf_acc17_wrap", ifw.out_overflow, ref_ovf(exp_q[0].total, 17));
          chk("ovf_acc17_sat", ifs.out_overflow, ref_ovf(exp_q[0].total, 17));
          chk("out_count", ifa.out_count, longint'(exp_q[0].len));
          chk("in_ready_while_valid", ifa.in_ready, 0);
          chk("busy_while_valid", busy_a, 1);
          if (!prev_valid) chk("valid_latency", longint'(cyc), longint'(exp_q[0].vcyc));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      prev_valid = ifa.out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check_reset_outs(input string tag);
    chk({tag, "_in_ready"}, ifa.in_ready, 1);
    chk({tag, "_out_valid"}, ifa.out_valid, 0);
    chk({tag, "_out_sum"}, ifa.out_sum, 0);
    chk({tag, "_out_count"}, ifa.out_count, 0);
    chk({tag, "_out_ovf"}, ifa.out_overflow, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_busy_w"}, busy_w, 0);
    chk({tag, "_busy_s"}, busy_s, 0);
  endtask

  task automatic model_accept(input logic [15:0] p, input logic [7:0] fl);
    if (!m_in_frame) begin
      m_len      = (fl == 8'd0) ? 1 : int'(fl);
      m_total    = 0;
      m_beats    = 0;
      m_in_frame = 1'b1;
    end
    m_total += longint'(p);
    m_beats++;
    if (m_beats == m_len) begin
      exp_q.push_back('{total: m_total, len: m_len, vcyc: cyc + 2});
      m_in_frame = 1'b0;
    end
  endtask

  task automatic send(input logic [15:0] p, input logic [7:0] fl, input int gap);
    bit ready_now;
    bit accepted;
    int budget;
    accepted   = 1'b0;
    budget     = 0;
    frame_len  = fl;
    in_product = p;
    in_valid   = 1'b1;
    while (!accepted) begin
      ready_now = ifa.in_ready;
      @(posedge clk);
      #1;
      if (ready_now) begin
        accepted = 1'b1;
      end else begin
        budget++;
        if (budget > 300) begin
          chk("beat_accept_timeout", ready_now, 1);
          break;
        end
      end
    end
    in_valid = 1'b0;
    if (accepted) model_accept(p, fl);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_a) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!ifa.out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid", ifa.out_valid, 1);
  endtask

  initial begin
    rst        = 1'b1;
    clear      = 1'b0;
    frame_len  = 8'd0;
    in_valid   = 1'b0;
    in_product = 16'd0;
    rdy_force  = 1'b1;
    rand_rdy   = 1'b0;
    m_in_frame = 1'b0;
    m_total    = 0;
    m_beats    = 0;
    m_len      = 1;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b0;

    // Async reset in the middle of a frame discards the partial sum.
    send(16'd100, 8'd4, 0);
    send(16'd200, 8'd4, 0);
    chk("mid_frame_busy", busy_a, 1);
    rst = 1'b1;
    #1;
    check_reset_outs("mid_reset");
    m_in_frame = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    send(16'd100, 8'd3, 0);
    send(16'd200, 8'd3, 0);
    send(16'd65025, 8'd3, 0);
    wait_drain();

    // Backpressure: result held while out_ready is low.
    rdy_force = 1'b0;
    send(16'hFFFF, 8'd1, 0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    chk("held_valid", ifa.out_valid, 1);
    chk("held_sum", ifa.out_sum, 24'h00FFFF);
    rdy_force = 1'b1;
    wait_drain();

    // Overflow in the 17-bit configurations.
    repeat (3) send(16'hFFFF, 8'd3, 0);
    wait_drain();

    // Gapped beats, frame_len changing mid-frame is ignored.
    send(16'($urandom), 8'd4, 2);
    repeat (3) send(16'($urandom), 8'd9, 2);
    wait_drain();

    // Clear in DONE withdraws the result.
    rdy_force = 1'b0;
    send(16'd1234, 8'd2, 0);
    send(16'd4321, 8'd2, 0);
    wait_valid();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clear_done_valid", ifa.out_valid, 0);
    chk("clear_done_busy", busy_a, 0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    rdy_force = 1'b1;

    // Clear in ACCUM drops the concurrent beat and the partial sum.
    send(16'd5000, 8'd3, 0);
    in_valid   = 1'b1;
    in_product = 16'd7000;
    clear      = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear_accum_busy", busy_a, 0);
    m_in_frame = 1'b0;
    send(16'd11, 8'd2, 0);
    send(16'd22, 8'd2, 0);
    wait_drain();

    // Randomized frames with random backpressure.
    rand_rdy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(0, 6);
      for (int b = 0; b < ((len == 0) ? 1 : len); b++) begin
        logic [15:0] p;
        logic [7:0]  fl;
        p  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        fl = (b == 0) ? 8'(len) : 8'($urandom);
        send(p, fl, $urandom_range(0, 2));
      end
    end
    wait_drain();
    rand_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
